ahb_slave_if: RTL and testbench
===============================

# ahb_slave_if

AHB-Lite slave front end of the AHB-to-APB bridge, sitting opposite the AHB master. It samples AHB address-phase controls and pipelines address, write data and direction two stages deep for the APB controller. It decodes the target APB peripheral and raises `valid` for each qualifying transfer. It also merges the APB controller's ready with an optional two-cycle ERROR response for unmapped addresses.

## Interface
Parameters:
- `BASE_ADDR`, 32'h8000_0000: start of the bridge window.
- `SLOT_SIZE`, 32'h0400_0000: size of each of the 3 peripheral slots.

Ports:
- `Hclk` in 1: single clock.
- `Hresetn` in 1: asynchronous assert, active-low reset.
- `Hwrite` in 1: AHB direction, 1 = write.
- `Hreadyin` in 1: AHB bus ready.
- `Htrans` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `Haddr` in 32: address-phase address.
- `Hwdata` in 32: data-phase write data.
- `Prdata` in 32: read data from the APB controller.
- `apb_ready` in 1: ready from the APB controller.
- `valid` out 1: qualifying transfer in the current address phase.
- `Haddr1`, `Haddr2` out 32: address pipeline, stages 1 and 2.
- `Hwdata1`, `Hwdata2` out 32: write-data pipeline, stages 1 and 2.
- `Hwritereg` out 1: `Hwrite` registered.
- `tempselx` out 3: one-hot peripheral select.
- `Hreadyout` out 1: slave ready to the AHB master.
- `Hresp` out 2: 00 OKAY, 01 ERROR.
- `Hrdata` out 32: read data to the AHB master.

## Operation
- Active transfer: `Htrans` is NONSEQ or SEQ, and `Hreadyin` = 1.
- Decode, combinational on `Haddr`:
  - slot0 = [BASE, BASE+SLOT) gives `tempselx` = 001.
  - slot1 gives 010; slot2 gives 100.
  - Outside all slots gives 000.
- `valid` = active transfer AND `tempselx` != 0. The output is combinational and has no added latency.
- Pipeline: registers update only when `Hreadyin` = 1 and hold otherwise.
  - `Haddr1`<=`Haddr`, `Haddr2`<=`Haddr1`.
  - `Hwdata1`<=`Hwdata`, `Hwdata2`<=`Hwdata1`.
  - `Hwritereg`<=`Hwrite`.
- IDLE and BUSY transfers update the pipeline but never assert `valid`.
- Response FSM states:
  - OKAY:
    - `Hresp` = 00.
    - `Hreadyout` = `apb_ready`.
    - `Hrdata` = `Prdata`.
  - ERR1:
    - `Hresp` = 01.
    - `Hreadyout` = 0.
    - `Hrdata` = 0.
  - ERR2:
    - `Hresp` = 01.
    - `Hreadyout` = 1.
    - `Hrdata` = 0.
- Transitions:
  - OKAY to ERR1 on an active transfer with `tempselx` = 000, only when `SLV_ERR_RESP_EN` is defined.
  - ERR1 to ERR2 unconditionally.
  - ERR2 to OKAY, or to ERR1 again if another unmapped active transfer is sampled in ERR2.
- Address phases arriving in ERR1 are ignored: `valid` is forced to 0 and the FSM does not branch. The master sees `Hreadyout` = 0, so it must hold them.
- `valid` is also forced to 0 in ERR2 for unmapped addresses. Mapped addresses in ERR2 assert `valid` normally.

## Timing
- Reset values:
  - All pipeline registers 0, `Hwritereg` 0.
  - FSM in OKAY, `Hresp` 00.
  - `Hreadyout` follows `apb_ready`, `Hrdata` follows `Prdata`.
  - `valid` 0 and `tempselx` 000 when inputs are idle.
- Reset asserted mid-transfer clears the pipeline and the FSM immediately, with no clock edge required. ERROR is abandoned and `Hresp` reads 00.
- `Haddr1` is valid 1 cycle after the address phase; `Haddr2` after 2 cycles.
- `Hwdata1` captures data-phase data 1 cycle after it appears.
- ERROR response: `Hresp` = 01 for exactly 2 cycles, starting the cycle after the offending address phase. `Hreadyout` is low in the first cycle and high in the second.
- `Hreadyin` low freezes the pipeline but does not stall the FSM.

## Configuration
- Macro: `SLV_ERR_RESP_EN`.
- Defined: unmapped active transfers get the two-cycle ERROR response above.
- Undefined:
  - FSM is removed.
  - `Hresp` is tied to 00.
  - `Hreadyout` = `apb_ready`, `Hrdata` = `Prdata`.
  - Unmapped transfers silently complete with `valid` = 0.

## Structure
- Shared package `ahb_apb_pkg` holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ).
  - HRESP encodings (OKAY/ERROR).
  - Slot base/size constants.
  - The response-FSM state enum.
- One sub-module, `ahb_addr_decode`: combinational `Haddr` to `tempselx`, reused later by the APB controller.

## Test plan
- Write NONSEQ to 8000_0001 with `Hwdata` AA next cycle:
  - `valid` = 1 and `tempselx` = 001 in the address cycle.
  - `Haddr1` = 8000_0001 at +1; `Haddr2` = 8000_0001 at +2.
  - `Hwdata1` = AA, `Hwritereg` = 1.
- Read NONSEQ to 8000_00A2, `Prdata` = 1234_5678, `apb_ready` = 1:
  - `valid` = 1, `Hwritereg` = 0.
  - `Hrdata` = 1234_5678, `Hresp` = 00.
- NONSEQ to 8400_0010 gives `tempselx` = 010. NONSEQ to 8800_0000 gives 100. IDLE to 8000_0000 gives `valid` = 0.
- NONSEQ to 9000_0000 with macro defined:
  - `valid` = 0.
  - Next cycle `Hresp` = 01 and `Hreadyout` = 0; then `Hresp` = 01 and `Hreadyout` = 1; then OKAY.
- Same stimulus with macro undefined: `Hresp` stays 00 and `Hreadyout` = `apb_ready`.
- `Hreadyin` = 0 for 3 cycles mid-sequence: pipeline holds. Then assert `Hresetn` = 0 asynchronously during ERR1: all registers go to 0 immediately and `Hresp` = 00.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB bridge definitions: transfer and response encodings,
// peripheral window defaults and the slave response-FSM state type.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [31:0] SLOT_BASE_DEF = 32'h8000_0000;
    localparam logic [31:0] SLOT_SIZE_DEF = 32'h0400_0000;

    typedef enum logic [1:0] {
        RESP_OKAY = 2'b00,
        RESP_ERR1 = 2'b01,
        RESP_ERR2 = 2'b10
    } resp_state_e;

    function automatic logic htrans_active(input logic [1:0] htrans, input logic hready);
        return hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational decode of an AHB address into a one-hot select for the
// three APB peripheral slots; all-zero when outside the bridge window.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = SLOT_BASE_DEF,
    parameter logic [31:0] SLOT_SIZE = SLOT_SIZE_DEF
) (
    input  logic [31:0] haddr_i,
    output logic [2:0]  tempselx_o
);

    // Limits kept at 34 bits so a window near the top of memory cannot wrap.
    localparam logic [33:0] LIM1 = {2'b00, SLOT_SIZE};
    localparam logic [33:0] LIM2 = {1'b0, SLOT_SIZE, 1'b0};
    localparam logic [33:0] LIM3 = LIM1 + LIM2;

    logic [33:0] offset_s;

    assign offset_s = {2'b00, haddr_i} - {2'b00, BASE_ADDR};

    // Slot select from the offset into the window.
    always_comb begin
        tempselx_o = 3'b000;
        if (offset_s[33]) begin
            tempselx_o = 3'b000;
        end else if (offset_s < LIM1) begin
            tempselx_o = 3'b001;
        end else if (offset_s < LIM2) begin
            tempselx_o = 3'b010;
        end else if (offset_s < LIM3) begin
            tempselx_o = 3'b100;
        end else begin
            tempselx_o = 3'b000;
        end
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: decode, two-stage
// address/data pipeline and response merge. Macro SLV_ERR_RESP_EN enables
// the two-cycle ERROR response for unmapped addresses.
module ahb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = SLOT_BASE_DEF,
    parameter logic [31:0] SLOT_SIZE = SLOT_SIZE_DEF
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    input  logic        apb_ready,
    output logic        valid,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic [2:0]  tempselx,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata
);

    logic        active_s;
    logic        mapped_s;
    logic [31:0] haddr1_q, haddr1_d;
    logic [31:0] haddr2_q, haddr2_d;
    logic [31:0] hwdata1_q, hwdata1_d;
    logic [31:0] hwdata2_q, hwdata2_d;
    logic        hwrite_q, hwrite_d;

    ahb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .SLOT_SIZE (SLOT_SIZE)
    ) u_decode (
        .haddr_i    (Haddr),
        .tempselx_o (tempselx)
    );

    assign active_s = htrans_active(Htrans, Hreadyin);
    assign mapped_s = |tempselx;

    // Pipeline next state: advance while the bus is ready, hold otherwise.
    always_comb begin
        haddr1_d  = haddr1_q;
        haddr2_d  = haddr2_q;
        hwdata1_d = hwdata1_q;
        hwdata2_d = hwdata2_q;
        hwrite_d  = hwrite_q;
        if (Hreadyin) begin
            haddr1_d  = Haddr;
            haddr2_d  = haddr1_q;
            hwdata1_d = Hwdata;
            hwdata2_d = hwdata1_q;
            hwrite_d  = Hwrite;
        end else begin
            haddr1_d  = haddr1_q;
            haddr2_d  = haddr2_q;
            hwdata1_d = hwdata1_q;
            hwdata2_d = hwdata2_q;
            hwrite_d  = hwrite_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            haddr1_q  <= 32'h0000_0000;
            haddr2_q  <= 32'h0000_0000;
            hwdata1_q <= 32'h0000_0000;
            hwdata2_q <= 32'h0000_0000;
            hwrite_q  <= 1'b0;
        end else begin
            haddr1_q  <= haddr1_d;
            haddr2_q  <= haddr2_d;
            hwdata1_q <= hwdata1_d;
            hwdata2_q <= hwdata2_d;
            hwrite_q  <= hwrite_d;
        end
    end

    assign Haddr1    = haddr1_q;
    assign Haddr2    = haddr2_q;
    assign Hwdata1   = hwdata1_q;
    assign Hwdata2   = hwdata2_q;
    assign Hwritereg = hwrite_q;

`ifdef SLV_ERR_RESP_EN
    resp_state_e state_q;

    // Response FSM; address phases seen in ERR1 are held off by Hreadyout=0.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= RESP_OKAY;
        end else begin
            case (state_q)
                RESP_OKAY: begin
                    if (active_s && !mapped_s) state_q <= RESP_ERR1;
                    else                       state_q <= RESP_OKAY;
                end
                RESP_ERR1: state_q <= RESP_ERR2;
                RESP_ERR2: begin
                    if (active_s && !mapped_s) state_q <= RESP_ERR1;
                    else                       state_q <= RESP_OKAY;
                end
                default:   state_q <= RESP_OKAY;
            endcase
        end
    end

    // Response outputs decoded from the FSM state.
    always_comb begin
        valid     = active_s && mapped_s && (state_q != RESP_ERR1);
        Hresp     = HRESP_OKAY;
        Hreadyout = apb_ready;
        Hrdata    = Prdata;
        case (state_q)
            RESP_OKAY: begin
                Hresp     = HRESP_OKAY;
                Hreadyout = apb_ready;
                Hrdata    = Prdata;
            end
            RESP_ERR1: begin
                Hresp     = HRESP_ERROR;
                Hreadyout = 1'b0;
                Hrdata    = 32'h0000_0000;
            end
            RESP_ERR2: begin
                Hresp     = HRESP_ERROR;
                Hreadyout = 1'b1;
                Hrdata    = 32'h0000_0000;
            end
            default: begin
                Hresp     = HRESP_OKAY;
                Hreadyout = apb_ready;
                Hrdata    = Prdata;
            end
        endcase
    end
`else
    assign valid     = active_s && mapped_s;
    assign Hresp     = HRESP_OKAY;
    assign Hreadyout = apb_ready;
    assign Hrdata    = Prdata;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// Randomized scoreboard bench for ahb_slave_if against a behavioural model.
`timescale 1ns/1ps
module tb_ahb_slave_if;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SLOT = 32'h0400_0000;
`ifdef SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        Hclk = 1'b0;
    logic        Hresetn = 1'b0;
    logic        Hwrite = 1'b0;
    logic        Hreadyin = 1'b0;
    logic [1:0]  Htrans = 2'b00;
    logic [31:0] Haddr = 32'h0;
    logic [31:0] Hwdata = 32'h0;
    logic [31:0] Prdata = 32'h0;
    logic        apb_ready = 1'b0;
    logic        valid, Hwritereg, Hreadyout;
    logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
    logic [2:0]  tempselx;
    logic [1:0]  Hresp;

    always #5 Hclk = ~Hclk;

    ahb_slave_if dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
        .apb_ready(apb_ready), .valid(valid), .Haddr1(Haddr1), .Haddr2(Haddr2),
        .Hwdata1(Hwdata1), .Hwdata2(Hwdata2), .Hwritereg(Hwritereg),
        .tempselx(tempselx), .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
    );

    typedef struct {
        logic        valid;
        logic [2:0]  sel;
        logic [31:0] a1, a2, w1, w2;
        logic        wr;
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
        string       tag;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    string cur_tag = "reset";
    event  chk_ev;

    // Reference state: address/data history and cycles of ERROR left (2 = first).
    logic [31:0] m_a1, m_a2, m_w1, m_w2;
    logic        m_wr;
    int          m_err;

    function automatic logic [2:0] model_sel(input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] idx;
        if (a < BASE) return 3'b000;
        off = a - BASE;
        idx = off / SLOT;
        if (idx < 32'd3) return 3'(1 << idx);
        return 3'b000;
    endfunction

    function automatic logic model_active(input logic [1:0] tr, input logic rdy);
        return rdy && (tr == 2'b10 || tr == 2'b11);
    endfunction

    task automatic model_clear();
        m_a1 = 32'h0; m_a2 = 32'h0; m_w1 = 32'h0; m_w2 = 32'h0;
        m_wr = 1'b0; m_err = 0;
    endtask

    // Advance the model across one rising edge using the inputs held over it.
    task automatic model_edge();
        if (!Hresetn) begin
            model_clear();
        end else begin
            if (Hreadyin) begin
                m_a2 = m_a1; m_a1 = Haddr;
                m_w2 = m_w1; m_w1 = Hwdata;
                m_wr = Hwrite;
            end
            if (m_err == 2) m_err = 1;
            else if (ERR_EN && model_active(Htrans, Hreadyin) && model_sel(Haddr) == 3'b000) m_err = 2;
            else m_err = 0;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.sel   = model_sel(Haddr);
        e.valid = model_active(Htrans, Hreadyin) && (e.sel != 3'b000) && (m_err != 2);
        e.a1 = m_a1; e.a2 = m_a2; e.w1 = m_w1; e.w2 = m_w2; e.wr = m_wr;
        e.rdy   = (m_err == 2) ? 1'b0 : (m_err == 1) ? 1'b1 : apb_ready;
        e.resp  = (m_err != 0) ? 2'b01 : 2'b00;
        e.rdata = (m_err != 0) ? 32'h0 : Prdata;
        e.tag   = cur_tag;
        q.push_back(e);
    endtask

    task automatic step(input string tag, input logic wr, input logic rdy, input logic [1:0] tr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] prd,
                        input logic ardy);
        @(posedge Hclk);
        #1;
        model_edge();
        cur_tag = tag;
        Hwrite = wr; Hreadyin = rdy; Htrans = tr; Haddr = addr;
        Hwdata = wd; Prdata = prd; apb_ready = ardy;
        push_expect();
    endtask

    // Assert reset between edges and check the cleared state before any clock edge.
    task automatic async_reset(input string tag);
        @(negedge Hclk);
        #2;
        Hresetn = 1'b0;
        #1;
        model_clear();
        cur_tag = tag;
        push_expect();
        -> chk_ev;
    endtask

    task automatic cmp(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs with each queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Hclk or chk_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.tag, "valid",     32'(valid),     32'(e.valid));
                cmp(e.tag, "tempselx",  32'(tempselx),  32'(e.sel));
                cmp(e.tag, "Haddr1",    Haddr1,         e.a1);
                cmp(e.tag, "Haddr2",    Haddr2,         e.a2);
                cmp(e.tag, "Hwdata1",   Hwdata1,        e.w1);
                cmp(e.tag, "Hwdata2",   Hwdata2,        e.w2);
                cmp(e.tag, "Hwritereg", 32'(Hwritereg), 32'(e.wr));
                cmp(e.tag, "Hreadyout", 32'(Hreadyout), 32'(e.rdy));
                cmp(e.tag, "Hresp",     32'(Hresp),     32'(e.resp));
                cmp(e.tag, "Hrdata",    Hrdata,         e.rdata);
            end
        end
    end

    initial begin
        logic [31:0] ra;
        model_clear();
        apb_ready = 1'b1;
        Prdata = 32'hCAFE_0001;
        #2;
        push_expect();
        -> chk_ev;
        step("in_reset", 1'b1, 1'b1, 2'b10, 32'h8000_0004, 32'h1111_1111, 32'h0, 1'b1);
        #2 Hresetn = 1'b1;

        step("wr_addr",  1'b1, 1'b1, 2'b10, 32'h8000_0001, 32'h0,        32'h0, 1'b1);
        step("wr_data",  1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0000_00AA, 32'h0, 1'b1);
        step("wr_pipe2", 1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0,        32'h0, 1'b1);
        step("rd_addr",  1'b0, 1'b1, 2'b10, 32'h8000_00A2, 32'h0,        32'h1234_5678, 1'b1);
        step("rd_data",  1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0,        32'h1234_5678, 1'b1);
        step("slot1",    1'b0, 1'b1, 2'b10, 32'h8400_0010, 32'h0,        32'h0, 1'b0);
        step("slot2",    1'b1, 1'b1, 2'b11, 32'h8800_0000, 32'h5, 32'h0, 1'b1);
        step("idle",     1'b0, 1'b1, 2'b00, 32'h8000_0000, 32'h6, 32'h0, 1'b1);
        step("busy",     1'b0, 1'b1, 2'b01, 32'h8000_0000, 32'h7, 32'h0, 1'b1);
        step("slot2_top",1'b0, 1'b1, 2'b11, 32'h8BFF_FFFF, 32'h8, 32'h0, 1'b1);
        step("below",    1'b0, 1'b0, 2'b10, 32'h7FFF_FFFF, 32'h9, 32'h0, 1'b1);
        step("past_top", 1'b0, 1'b1, 2'b00, 32'h8C00_0000, 32'hA, 32'h0, 1'b1);

        step("unmapped", 1'b0, 1'b1, 2'b10, 32'h9000_0000, 32'h0, 32'hDEAD_0000, 1'b1);
        step("err_c1",   1'b0, 1'b1, 2'b00, 32'h0,         32'h0, 32'hDEAD_0001, 1'b1);
        step("err_c2",   1'b0, 1'b1, 2'b00, 32'h0,         32'h0, 32'hDEAD_0002, 1'b0);
        step("err_done", 1'b0, 1'b1, 2'b00, 32'h0,         32'h0, 32'hDEAD_0003, 1'b0);

        step("pre_hold", 1'b1, 1'b1, 2'b10, 32'h8000_0100, 32'h0000_0BB0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("hold", 1'b0, 1'b0, 2'b10, 32'h8400_0200 + 32'(i), 32'h0000_0CC0 + 32'(i), 32'h0, 1'b0);
        step("resume",   1'b0, 1'b1, 2'b11, 32'h8000_0300, 32'h0000_0DD0, 32'h0, 1'b1);

        step("unmap_rst", 1'b0, 1'b1, 2'b10, 32'hF000_0000, 32'h0000_0EE0, 32'h0, 1'b1);
        step("in_err1",   1'b0, 1'b1, 2'b10, 32'hF000_0000, 32'h0000_0EE1, 32'h0, 1'b1);
        async_reset("async_rst");
        step("rst_hold",  1'b0, 1'b1, 2'b10, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
        #2 Hresetn = 1'b1;

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = BASE + $urandom_range(0, 32'h0BFF_FFFF);
                1:       ra = BASE + 32'h0C00_0000 - 32'($urandom_range(0, 3));
                2:       ra = BASE - 32'($urandom_range(1, 4));
                default: ra = $urandom;
            endcase
            step("random", 1'($urandom), ($urandom_range(0, 7) != 0), 2'($urandom), ra,
                 $urandom, $urandom, 1'($urandom));
        end

        @(negedge Hclk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
